// File: rtl/inv_mixcolumns_seq.sv
// inv_mixcolumns_seq: AES InvMixColumns over a 128-bit state, one column per clock.
// A state is captured in IDLE, its four columns are mixed in place during CALC,
// and the finished state is presented in DONE until the downstream handshake.
// Optional build macro INVMIX_FWD_EN adds a "fwd" input that selects forward
// MixColumns for the whole operation (sampled when the state is accepted).
module inv_mixcolumns_seq #(
  parameter int           COLS      = 4,
  parameter logic [127:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
`ifdef INVMIX_FWD_EN
  ,
  input  logic         fwd
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [1:0]   col_cnt_reg, col_cnt_next;
  logic [127:0] state_reg, state_next;
  logic         load, mix_en;
  logic [31:0]  col_in, col_mixed;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul_b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] mul_d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul_e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // Inverse column mix; byte a0 is the most significant byte of the column
  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
            mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3),
            mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3),
            mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3)};
  endfunction

`ifdef INVMIX_FWD_EN
  logic fwd_reg;

  // Forward column mix (coefficients 02 03 01 01, rotated per row)
  function automatic logic [31:0] fwd_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Mix direction is fixed for the whole operation by the sampled fwd bit
  always_comb begin
    col_mixed = fwd_reg ? fwd_mix(col_in) : inv_mix(col_in);
  end
`else
  // Inverse-only build
  always_comb begin
    col_mixed = inv_mix(col_in);
  end
`endif

  // Select the column currently being processed
  always_comb begin
    col_in = state_reg[127:96];
    case (col_cnt_reg)
      2'd0:    col_in = state_reg[127:96];
      2'd1:    col_in = state_reg[95:64];
      2'd2:    col_in = state_reg[63:32];
      default: col_in = state_reg[31:0];
    endcase
  end

  // Only the active column is replaced; the other three pass through unchanged
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign state_next[127-32*gi -: 32] =
        (col_cnt_reg == 2'(gi)) ? col_mixed : state_reg[127-32*gi -: 32];
    end
  endgenerate

  // Next-state logic and handshake outputs
  always_comb begin
    fsm_next     = fsm_reg;
    col_cnt_next = col_cnt_reg;
    load         = 1'b0;
    mix_en       = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (fsm_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fsm_next     = CALC;
          col_cnt_next = 2'd0;
          load         = 1'b1;
        end
      end
      CALC: begin
        busy   = 1'b1;
        mix_en = 1'b1;
        if (col_cnt_reg == 2'(COLS - 1)) begin
          fsm_next     = DONE;
          col_cnt_next = 2'd0;
        end else begin
          col_cnt_next = col_cnt_reg + 2'd1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // FSM, column counter and state register; reset wins over a capture
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg     <= IDLE;
      col_cnt_reg <= 2'd0;
      state_reg   <= RESET_VAL;
`ifdef INVMIX_FWD_EN
      fwd_reg     <= 1'b0;
`endif
    end else begin
      fsm_reg     <= fsm_next;
      col_cnt_reg <= col_cnt_next;
      if (load) begin
        state_reg <= in_state;
`ifdef INVMIX_FWD_EN
        fwd_reg   <= fwd;
`endif
      end else if (mix_en) begin
        state_reg <= state_next;
      end
    end
  end

  assign out_state = state_reg;

endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
// tb_inv_mixcolumns_seq: scoreboard bench for inv_mixcolumns_seq.
// Expected states are queued at acceptance and compared when out_valid rises.
module tb_inv_mixcolumns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;
  logic         busy;
`ifdef INVMIX_FWD_EN
  logic         fwd = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_results = 0;
  logic prev_valid = 1'b0;
  logic [127:0] exp_q[$];
  int rise_q[$];

  inv_mixcolumns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
`ifdef INVMIX_FWD_EN
    ,
    .fwd       (fwd)
`endif
  );

  always #5 clk = ~clk;

  // cycle counter (edge index)
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference multiply: shift-and-add with reduction by 0x11B
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (({x[6:0], 1'b0}) ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference InvMixColumns via the circulant matrix rows (0e 0b 0d 09)
  function automatic logic [127:0] model_inv(input logic [127:0] s);
    logic [7:0] coef[4];
    logic [7:0] a[4];
    logic [7:0] acc;
    logic [127:0] res = '0;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c + k) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[(k - r + 4) % 4], a[k]);
        res[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  // Output monitor: compare each new result against the scoreboard head
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      n_results <= n_results + 1;
      rise_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_result", out_valid, 1'b0);
      else check("result", out_state, exp_q.pop_front());
      check("done_in_ready", in_ready, 1'b0);
      check("done_busy", busy, 1'b1);
      $display("result cyc=%0d out_state=%h", cyc, out_state);
    end
    prev_valid <= out_valid;
  end

  // Offer a state, wait for acceptance and queue its expected result
  task automatic send(input logic [127:0] s, input logic [127:0] e);
    int n = 0;
    @(negedge clk);
    in_state = s;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
    $display("accept cyc=%0d in_state=%h", acc_cyc, s);
  endtask

  // Wait for out_valid with a bound; returns cycles since acceptance
  task automatic wait_done(output int lat);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("done_timeout", 1'b0, 1'b1);
    lat = cyc - acc_cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_out_state"}, out_state, 128'h0);
  endtask

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  initial begin
    int lat;
    int base;
    logic [127:0] s;
    logic [127:0] sb;

    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // 1: known vector, latency 4, handshake returns to IDLE
    out_ready = 1'b1;
    send(V1_IN, V1_OUT);
    wait_done(lat);
    check("t1_latency", 128'(lat), 128'd4);
    check("t1_value", out_state, V1_OUT);
    @(negedge clk);
    check("t1_idle_ready", in_ready, 1'b1);
    check("t1_idle_valid", out_valid, 1'b0);

    // 2: back-pressure holds the result
    out_ready = 1'b0;
    send(V2_IN, V2_OUT);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_state", out_state, V2_OUT);
      check("t2_hold_in_ready", in_ready, 1'b0);
      check("t2_hold_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_release_valid", out_valid, 1'b0);
    check("t2_release_ready", in_ready, 1'b1);

    // 3: reset during the second CALC cycle aborts the operation
    send(V1_IN, V1_OUT);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check_reset_state("t3_abort");
    repeat (6) @(negedge clk);
    check("t3_no_valid", out_valid, 1'b0);
    send(V2_IN, V2_OUT);
    wait_done(lat);
    check("t3_resume_latency", 128'(lat), 128'd4);
    wait_idle();

    // in_valid together with rst: nothing captured
    in_state = V1_IN;
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_state("rst_vs_valid");

    // 4: in_valid held high across two states
    base = n_results;
    rise_q.delete();
    @(negedge clk);
    s  = 128'h00112233_44556677_8899aabb_ccddeeff;
    sb = 128'h63536473_a1b2c3d4_0f1e2d3c_deadbeef;
    in_state = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1 exp_q.push_back(model_inv(s));
    in_state = sb;
    begin
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) check("t4_accept_timeout", 1'b0, 1'b1);
    end
    @(posedge clk);
    #1 exp_q.push_back(model_inv(sb));
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("t4_count", 128'(n_results - base), 128'd2);
    if (rise_q.size() == 2) check("t4_spacing", 128'(rise_q[1] - rise_q[0]), 128'd6);
    else check("t4_rises", 128'(rise_q.size()), 128'd2);

    // 5: input changes during CALC are ignored
    s = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    send(s, model_inv(s));
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_done(lat);
    check("t5_value", out_state, model_inv(s));
    wait_idle();

    // random states with random back-pressure
    for (int i = 0; i < 6; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      send(s, model_inv(s));
      wait_done(lat);
      check("rnd_latency", 128'(lat), 128'd4);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      wait_idle();
    end

`ifdef INVMIX_FWD_EN
    // 6: forward mode and a round trip through inverse mode
    fwd = 1'b1;
    send(V1_OUT, V1_IN);
    fwd = 1'b0;
    wait_done(lat);
    check("t6_fwd_latency", 128'(lat), 128'd4);
    wait_idle();
    send(V1_IN, V1_OUT);
    wait_done(lat);
    check("t6_roundtrip", out_state, V1_OUT);
    wait_idle();
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
